// File: rtl/vga_timing_rx.sv
// vga_timing_rx: sink-side VGA timing decoder/checker with lock FSM.
// Optional frame/error statistics counters built when VGA_RX_STAT_EN is defined.
module vga_timing_rx #(
   parameter int H_TOTAL     = 800,
   parameter int V_TOTAL     = 525,
   parameter int H_W         = 11,
   parameter int V_W         = 10,
   parameter int LOCK_FRAMES = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           h_sync_i,
   input  logic           v_sync_i,
   input  logic           disp_i,
   output logic [H_W-1:0] x_o,
   output logic [V_W-1:0] y_o,
   output logic           pix_valid_o,
   output logic           line_start_o,
   output logic           frame_start_o,
   output logic [H_W-1:0] h_total_o,
   output logic [V_W-1:0] v_total_o,
   output logic           locked_o,
   output logic           err_o,
   output logic [15:0]    frm_cnt_o,
   output logic [15:0]    err_cnt_o
);
   localparam logic [1:0] SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2;
   localparam int GW = $clog2(LOCK_FRAMES + 1);
   logic           h_r_q, v_r_q, disp_r_q, h_p_q, v_p_q, had_q, had_d, bad_q, bad_d;
   logic           ls_q, fs_q, err_q, err_d;
   logic [H_W-1:0] h_cnt_q, h_cnt_d, h_nxt, x_q, x_d, ht_q, ht_d;
   logic [V_W-1:0] ln_q, ln_d, v_nxt, y_q, y_d, vt_q, vt_d;
   logic [1:0]     st_q, st_d;
   logic [GW-1:0]  good_q, good_d, good_inc;
   logic           h_fall, v_fall, h_mis, v_mis, tmo, frame_ok;
   always_comb begin
      h_fall   = h_p_q & ~h_r_q;
      v_fall   = v_p_q & ~v_r_q;
      h_nxt    = h_cnt_q + 1'b1;
      v_nxt    = ln_q + 1'b1;
      h_mis    = h_fall & (h_nxt != H_W'(H_TOTAL));
      v_mis    = v_nxt != V_W'(V_TOTAL);
      tmo      = ~h_fall & (h_cnt_q == H_W'(2 * H_TOTAL));
      // a frame is only good if its closing v edge lands on an h edge
      frame_ok = ~v_mis & h_fall & ~(bad_q | h_mis);
      err_d    = (st_q != SEARCH) & (h_mis | (v_fall & (~h_fall | v_mis)) | tmo);
      good_inc = good_q + 1'b1;
      st_d     = tmo ? SEARCH :
                 st_q == SEARCH ? (v_fall ? CHECK : SEARCH) :
                 st_q == CHECK  ? ((v_fall & frame_ok & (good_inc == GW'(LOCK_FRAMES))) ? LOCKED : CHECK) :
                 (err_d ? CHECK : LOCKED);
      good_d   = (st_q != CHECK || tmo) ? '0 : v_fall ? (frame_ok ? good_inc : '0) : good_q;
      h_cnt_d  = h_fall ? '0 : (&h_cnt_q ? h_cnt_q : h_nxt);
      ln_d     = v_fall ? '0 : (h_fall & ~&ln_q) ? v_nxt : ln_q;
      ht_d     = h_fall ? h_nxt : ht_q;
      vt_d     = v_fall ? v_nxt : vt_q;
      x_d      = h_fall ? H_W'(disp_r_q) : disp_r_q ? x_q + 1'b1 : x_q;
      y_d      = v_fall ? '0 : (h_fall & had_q) ? y_q + 1'b1 : y_q;
      // disp seen on the edge cycle already belongs to the new line
      had_d    = h_fall ? disp_r_q : had_q | disp_r_q;
      bad_d    = v_fall ? 1'b0 : bad_q | h_mis;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         {h_r_q, v_r_q, disp_r_q, h_p_q, v_p_q, had_q, bad_q, ls_q, fs_q, err_q} <= '0;
         h_cnt_q <= '0;
         x_q     <= '0;
         ht_q    <= '0;
         ln_q    <= '0;
         y_q     <= '0;
         vt_q    <= '0;
         st_q    <= SEARCH;
         good_q  <= '0;
      end else begin
         h_r_q    <= h_sync_i;
         v_r_q    <= v_sync_i;
         disp_r_q <= disp_i;
         h_p_q    <= h_r_q;
         v_p_q    <= v_r_q;
         had_q    <= had_d;
         bad_q    <= bad_d;
         ls_q     <= h_fall;
         fs_q     <= v_fall;
         err_q    <= err_d;
         h_cnt_q  <= h_cnt_d;
         x_q      <= x_d;
         ht_q     <= ht_d;
         ln_q     <= ln_d;
         y_q      <= y_d;
         vt_q     <= vt_d;
         st_q     <= st_d;
         good_q   <= good_d;
      end
   end
   assign x_o           = x_q;
   assign y_o           = y_q;
   assign locked_o      = st_q == LOCKED;
   assign pix_valid_o   = disp_r_q & locked_o;
   assign line_start_o  = ls_q;
   assign frame_start_o = fs_q;
   assign h_total_o     = ht_q;
   assign v_total_o     = vt_q;
   assign err_o         = err_q;
`ifdef VGA_RX_STAT_EN
   logic [15:0] frm_q, ecnt_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         frm_q  <= '0;
         ecnt_q <= '0;
      end else begin
         if (v_fall && !(&frm_q)) frm_q <= frm_q + 1'b1;
         if (err_d && !(&ecnt_q)) ecnt_q <= ecnt_q + 1'b1;
      end
   end
   assign frm_cnt_o = frm_q;
   assign err_cnt_o = ecnt_q;
`else
   assign frm_cnt_o = '0;
   assign err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: scoreboard bench on scaled 40x20 timing; driver queues expectations, monitor checks.
module tb_vga_timing_rx;
   localparam int HT = 40, VT = 20, HS = 4, VS = 2, HAS = 8, HAL = 24, VAS = 3, VAL = 12;
   logic clk = 0, rst = 1, h_sync = 1, v_sync = 1, disp = 0;
   logic [10:0] x, ht_o;
   logic [9:0]  y, vt_o;
   logic        pix, ls, fs, locked, err;
   logic [15:0] frm, ecnt;
   typedef struct {int cyc; int sig; int val;} item_t;
   item_t sq[$];
   int eq[$];
   int cyc = 0, compared = 0, mismatched = 0;
   int prev_len = -1, nfr = 0, nerr = 0, c_last = 0;
   bit lk = 0, armed = 0, full_prev = 0;
   string nm [10] = '{"x", "y", "pix_valid", "line_start", "frame_start", "h_total", "v_total", "locked", "frm_cnt", "err_cnt"};

   vga_timing_rx #(.H_TOTAL(HT), .V_TOTAL(VT)) dut (
      .clk(clk), .rst(rst), .h_sync_i(h_sync), .v_sync_i(v_sync), .disp_i(disp),
      .x_o(x), .y_o(y), .pix_valid_o(pix), .line_start_o(ls), .frame_start_o(fs),
      .h_total_o(ht_o), .v_total_o(vt_o), .locked_o(locked), .err_o(err),
      .frm_cnt_o(frm), .err_cnt_o(ecnt));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int get(input int s);
      case (s)
         0: return int'(x);
         1: return int'(y);
         2: return int'(pix);
         3: return int'(ls);
         4: return int'(fs);
         5: return int'(ht_o);
         6: return int'(vt_o);
         7: return int'(locked);
         8: return int'(frm);
         default: return int'(ecnt);
      endcase
   endfunction

   task automatic push(input int c, input int s, input int v);
      item_t it;
      it.cyc = c; it.sig = s; it.val = v;
      sq.push_back(it);
   endtask

   always @(negedge clk) begin
      bit e;
      e = 0;
      for (int i = sq.size() - 1; i >= 0; i--)
         if (sq[i].cyc <= cyc) begin
            compared++;
            if (sq[i].cyc < cyc || get(sq[i].sig) != sq[i].val) begin
               mismatched++;
               $display("FAIL %s @cyc %0d: got %0d, want %0d", nm[sq[i].sig], sq[i].cyc, get(sq[i].sig), sq[i].val);
            end
            sq.delete(i);
         end
      for (int i = eq.size() - 1; i >= 0; i--)
         if (eq[i] <= cyc) begin
            if (eq[i] == cyc) e = 1;
            else begin
               compared++; mismatched++;
               $display("FAIL err_o @cyc %0d: got 0, want 1", eq[i]);
            end
            eq.delete(i);
         end
      if (err || e) begin
         compared++;
         if (err !== e) begin
            mismatched++;
            $display("FAIL err_o @cyc %0d: got %0b, want %0b", cyc, err, e);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         h_sync = 1; v_sync = 1; disp = 0;
      end
   endtask

   task automatic hold(input int n);
      if (armed) begin
         eq.push_back(c_last + 2 * HT + 3);
         push(c_last + 2 * HT + 3, 7, 0);
         nerr++;
      end
      lk = 0; armed = 0;
      idle(n);
      prev_len = -1; full_prev = 0;
   endtask

   task automatic frame(input bit lk_fs, input int bad_v, input bit all_bad, input int rst_v);
      for (int v = 0; v < VT; v++) begin
         int hl;
         hl = (all_bad || v == bad_v) ? HT + 1 : HT;
         for (int h = 0; h < hl; h++) begin
            @(posedge clk); #1;
            h_sync = h >= HS;
            v_sync = v >= VS;
            disp = h >= HAS && h < HAS + HAL && v >= VAS && v < VAS + VAL;
            rst = v == rst_v && h == 10;
            if (h == 0) begin
               if (v == VT - 1) c_last = cyc;
               push(cyc + 2, 3, 1);
               if (prev_len >= 0) push(cyc + 2, 5, prev_len);
               if (armed && prev_len >= 0 && prev_len != HT) begin
                  eq.push_back(cyc + 2);
                  push(cyc + 2, 7, 0);
                  nerr++; lk = 0;
               end
               if (v == 0) begin
                  push(cyc + 2, 4, 1);
                  push(cyc + 2, 7, int'(lk_fs));
                  if (full_prev) push(cyc + 2, 6, VT);
                  lk = lk_fs; armed = 1; nfr++;
               end
               prev_len = hl;
            end
            if ((v == VAS && h == HAS) || (v == VAS + VAL - 1 && h == HAS + HAL - 1)) begin
               push(cyc + 1, 2, int'(lk));
               if (lk) begin
                  push(cyc + 1, 0, v == VAS ? 0 : HAL - 1);
                  push(cyc + 1, 1, v == VAS ? 0 : VAL - 1);
               end
            end
            if (rst) begin
               for (int s = 0; s < 8; s++) push(cyc + 1, s, 0);
               lk = 0; armed = 0; prev_len = -1; nfr = 0; nerr = 0;
            end
         end
      end
      full_prev = rst_v < 0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 10; s++) push(cyc, s, 0);
      @(posedge clk); #1;
      rst = 0;
      idle(5);
      frame(0, -1, 0, -1);
      frame(0, -1, 0, -1);
      frame(1, -1, 0, -1);
      frame(1, -1, 0, -1);
      frame(1, 5, 0, -1);
      frame(0, -1, 0, -1);
      frame(0, -1, 0, -1);
      frame(1, -1, 0, -1);
      hold(100);
      frame(0, -1, 0, -1);
      frame(0, -1, 0, -1);
      frame(1, -1, 0, -1);
      frame(1, -1, 0, 8);
      frame(0, -1, 0, -1);
      frame(0, -1, 0, -1);
      frame(1, -1, 0, -1);
      frame(1, -1, 1, -1);
      frame(0, -1, 1, -1);
      frame(0, -1, 1, -1);
      frame(0, -1, 0, -1);
      frame(0, -1, 0, -1);
      frame(1, -1, 0, -1);
      idle(10);
`ifdef VGA_RX_STAT_EN
      push(cyc + 1, 8, nfr);
      push(cyc + 1, 9, nerr);
`else
      push(cyc + 1, 8, 0);
      push(cyc + 1, 9, 0);
`endif
      idle(5);
      foreach (sq[i]) begin
         mismatched++;
         $display("FAIL %s @cyc %0d: never checked, want %0d", nm[sq[i].sig], sq[i].cyc, sq[i].val);
      end
      foreach (eq[i]) begin
         mismatched++;
         $display("FAIL err_o @cyc %0d: never seen, want 1", eq[i]);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
